pipelined_carry_skip_adder: RTL and testbench

Parametrised, pipelined carry-skip adder. It is the next generation of the team's 8-bit combinational carry-skip adder.
- WIDTH operand bits are split into skip blocks of BLOCK bits, with one skip block evaluated per pipeline stage.
- Operands flow through a valid/ready pipeline with full backpressure.
- The block sits in datapaths that need wide adds at high clock rates with a streaming handshake.

---
 rtl/csa_pkg.sv | 20 ++
 rtl/csa_skip_block.sv | 26 ++
 rtl/pipelined_carry_skip_adder.sv | 101 ++++++++++
 tb/tb_pipelined_carry_skip_adder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// csa_pkg: shared types and helpers for the pipelined carry-skip adder.
// Holds the stage count helper, geometry check and per-stage control record.
package csa_pkg;

    typedef struct packed {
        logic valid;
        logic sub;
        logic carry;
        logic ovf;
    } csa_ctrl_t;

    function automatic int nblk(input int width, input int block);
        return width / block;
    endfunction

    function automatic bit csa_geom_ok(input int width, input int block);
        return (block > 0) && (width >= block) && (width % block == 0);
    endfunction

endpackage

// File: rtl/csa_skip_block.sv
// csa_skip_block: BLOCK-bit ripple adder with carry-skip mux on the block carry out.
module csa_skip_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    input  logic             c_i,
    output logic [BLOCK-1:0] s_o,
    output logic             c_o,
    output logic             p_o
);
    logic rip;

    always_comb begin
        rip = c_i;
        s_o = '0;
        for (int i = 0; i < BLOCK; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ rip;
            rip    = (a_i[i] & b_i[i]) | ((a_i[i] ^ b_i[i]) & rip);
        end
    end

    assign p_o = &(a_i ^ b_i);
    assign c_o = p_o ? c_i : rip;

endmodule

// File: rtl/pipelined_carry_skip_adder.sv
// pipelined_carry_skip_adder: valid/ready carry-skip adder, one skip block per stage.
// Define CSA_SUB_EN to add a per-beat sub input computing a + ~b + 1.
module pipelined_carry_skip_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NBLK = nblk(WIDTH, BLOCK);

    if (!csa_geom_ok(WIDTH, BLOCK)) begin : g_bad_geom
        $error("WIDTH must be a non-zero multiple of BLOCK");
    end

    // Operands shift right one block per stage; the sum fills in from the top.
    typedef struct packed {
        csa_ctrl_t        ctrl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } stage_t;

    stage_t st_q [NBLK];
    stage_t st_d [NBLK];
    logic   stall;
    logic   sub_w;

`ifdef CSA_SUB_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    assign stall    = st_q[NBLK-1].ctrl.valid && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        stage_t           prev;
        logic [BLOCK-1:0] bb;
        logic [BLOCK-1:0] s_blk;
        logic             co;
        logic             p_unused;
        if (k == 0) begin : g_src
            assign prev.ctrl.valid = in_valid;
            assign prev.ctrl.sub   = sub_w;
            assign prev.ctrl.carry = sub_w | cin;
            assign prev.ctrl.ovf   = 1'b0;
            assign prev.a          = a;
            assign prev.b          = b;
            assign prev.s          = '0;
        end else begin : g_src
            assign prev = st_q[k-1];
        end
        assign bb = prev.b[BLOCK-1:0] ^ {BLOCK{prev.ctrl.sub}};
        csa_skip_block #(.BLOCK(BLOCK)) u_blk (
            .a_i(prev.a[BLOCK-1:0]),
            .b_i(bb),
            .c_i(prev.ctrl.carry),
            .s_o(s_blk),
            .c_o(co),
            .p_o(p_unused)
        );
        assign st_d[k].ctrl.valid = prev.ctrl.valid;
        assign st_d[k].ctrl.sub   = prev.ctrl.sub;
        assign st_d[k].ctrl.carry = co;
        // Carry into the MSB is recovered from the MSB sum bit of the last block.
        assign st_d[k].ctrl.ovf   = (k == NBLK - 1) && (co ^ s_blk[BLOCK-1] ^ prev.a[BLOCK-1] ^ bb[BLOCK-1]);
        assign st_d[k].a          = prev.a >> BLOCK;
        assign st_d[k].b          = prev.b >> BLOCK;
        assign st_d[k].s          = (prev.s >> BLOCK) | (WIDTH'(s_blk) << (WIDTH - BLOCK));
    end

    always_ff @(posedge clk) begin
        if (rst)
            st_q <= '{default: '0};
        else if (!stall)
            st_q <= st_d;
    end

    assign out_valid = st_q[NBLK-1].ctrl.valid;
    assign sum       = st_q[NBLK-1].s;
    assign cout      = st_q[NBLK-1].ctrl.carry;
    assign ovf       = st_q[NBLK-1].ctrl.ovf;

endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// tb_pipelined_carry_skip_adder: directed checks of the 8-bit, 2-stage carry-skip adder pipeline.
module tb_pipelined_carry_skip_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         n_cmp = 0;
    int         n_bad = 0;

    pipelined_carry_skip_adder #(.WIDTH(8), .BLOCK(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .cin(cin),
`ifdef CSA_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum(sum),
        .cout(cout),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({out_valid, sum, cout, ovf} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b required all 0", out_valid, sum, cout, ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready: got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    // One beat, checks latency (not valid after 1 cycle) and the result after 2.
    task automatic test_single(input string nm, input logic [7:0] av, input logic [7:0] bv,
                               input logic ci, input logic sb,
                               input logic [7:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_latency: out_valid=%b one cycle after accept, required 0", nm, out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, sum, cout, ovf} !== {1'b1, es, ec, eo}) begin
            n_bad++;
            $display("FAIL %s: got valid=%b sum=%h cout=%b ovf=%b required 1 %h %b %b",
                     nm, out_valid, sum, cout, ovf, es, ec, eo);
        end
        sub = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [3] = '{8'h01, 8'hFF, 8'h80};
        logic [7:0] vb [3] = '{8'h02, 8'h01, 8'h80};
        logic       vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [9:0] ex [3] = '{{8'h03, 1'b0, 1'b0}, {8'h00, 1'b1, 1'b0}, {8'h01, 1'b1, 1'b1}};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                n_cmp++;
                if ({out_valid, sum, cout, ovf} !== {1'b1, ex[i-2]}) begin
                    n_bad++;
                    $display("FAIL b2b_%0d: got valid=%b sum=%h cout=%b ovf=%b required 1 %h %b %b",
                             i - 2, out_valid, sum, cout, ovf, ex[i-2][9:2], ex[i-2][1], ex[i-2][0]);
                end
            end
            if (i < 3) begin
                a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        cin = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        a = 8'h58; b = 8'hF4; in_valid = 1'b1;
        @(negedge clk);
        a = 8'h4A; b = 8'hC8;
        @(negedge clk);
        a = 8'h73; b = 8'hCC; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_cmp++;
            if ({in_ready, out_valid, sum, cout} !== {1'b0, 1'b1, 8'h4C, 1'b1}) begin
                n_bad++;
                $display("FAIL stall_%0d: got in_ready=%b valid=%b sum=%h cout=%b required 0 1 4c 1",
                         i, in_ready, out_valid, sum, cout);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, sum, cout} !== {1'b1, 1'b1, 8'h4C, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_release: got in_ready=%b valid=%b sum=%h cout=%b required 1 1 4c 1",
                     in_ready, out_valid, sum, cout);
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, sum, cout} !== {1'b1, 8'h12, 1'b1}) begin
            n_bad++;
            $display("FAIL stream_beat2: got valid=%b sum=%h cout=%b required 1 12 1", out_valid, sum, cout);
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, sum, cout} !== {1'b1, 8'h3F, 1'b1}) begin
            n_bad++;
            $display("FAIL stream_beat3: got valid=%b sum=%h cout=%b required 1 3f 1", out_valid, sum, cout);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_nodup: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1; cin = 1'b0;
        @(negedge clk);
        a = 8'h11; b = 8'h22; in_valid = 1'b1;
        @(negedge clk);
        a = 8'h33; b = 8'h44;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_mid_%0d: out_valid=%b required 0", i, out_valid);
            end
            @(negedge clk);
        end
        test_single("after_reset", 8'hF3, 8'h53, 1'b0, 1'b0, 8'h46, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single("basic_ovf", 8'hA0, 8'hA4, 1'b0, 1'b0, 8'h44, 1'b1, 1'b1);
        test_single("basic_plain", 8'h35, 8'h0F, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0);
        test_single("full_skip", 8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        test_back_to_back();
        test_backpressure();
        test_single("signed_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        test_reset_mid();
`ifdef CSA_SUB_EN
        test_single("sub_pos", 8'h35, 8'h0F, 1'b0, 1'b1, 8'h26, 1'b1, 1'b0);
        test_single("sub_neg", 8'h0F, 8'h35, 1'b1, 1'b1, 8'hDA, 1'b0, 1'b0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
